// File: rtl/button_debouncer_if.sv
// Button debouncer bundle: sample strobe and raw pins in,
// clean levels and press/release strobes out.
interface button_debouncer_if #(
  parameter int N = 4
);
  logic         tick_in;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  modport master (
    output tick_in,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  tick_in,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_debouncer.sv
// Per-button debouncer: 2-FF sync, tick-qualified stability
// counter, registered level and one-cycle press/release strobes.
module button_debouncer #(
  parameter int NUM_BTN      = 4,
  parameter int STABLE_TICKS = 20,
  parameter int ACTIVE_LOW   = 0
) (
  input logic               clk,
  input logic               rst_n,
  button_debouncer_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  // Sync flops idle at the raw released level.
  localparam logic [NUM_BTN-1:0] IDLE =
    (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : '0;

  logic [NUM_BTN-1:0] meta_q;
  logic [NUM_BTN-1:0] sync_q;
  logic [NUM_BTN-1:0] s;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] rel_q, rel_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  assign s = (ACTIVE_LOW != 0) ? ~sync_q : sync_q;

  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (!bus.tick_in) begin
        cnt_d[i] = cnt_q[i];
      end else if (cnt_q[i] != LAST) begin
        cnt_d[i] = cnt_q[i] + ONE;
      end else begin
        cnt_d[i]   = '0;
        level_d[i] = s[i];
        press_d[i] = s[i];
        rel_d[i]   = ~s[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= IDLE;
      sync_q  <= IDLE;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++)
        cnt_q[i] <= '0;
    end else begin
      meta_q  <= bus.btn_raw;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < NUM_BTN; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = rel_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: two debouncer configs, directed pin vectors,
// expected strobe events queued and checked by monitors.
module tb_button_debouncer;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lvl;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  qa[$];
  ev_t  qb[$];
  ev_t  ea, eb;

  button_debouncer_if #(.N(4)) ifa ();
  button_debouncer_if #(.N(4)) ifb ();

  button_debouncer #(
    .NUM_BTN(4), .STABLE_TICKS(4), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  button_debouncer #(
    .NUM_BTN(4), .STABLE_TICKS(1), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A's tick is sampled on edges whose cycle number is 0 mod 4.
  always @(negedge clk) ifa.tick_in = (cyc % 4 == 3);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic push_a(input int c, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lvl = l;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lvl = l;
    qb.push_back(e);
  endtask

  // Land on a negedge with cyc%4==1: a pin driven here reaches s
  // for edge cyc+3, a tick edge, so the 4th tick is edge cyc+15.
  task automatic align();
    do @(negedge clk); while (cyc % 4 != 1);
  endtask

  always @(negedge clk) begin
    if ((ifa.btn_press | ifa.btn_release) != 4'b0) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_strobe",
            {24'b0, ifa.btn_press, ifa.btn_release}, 32'h0);
      end else begin
        ea = qa.pop_front();
        chk("a_cycle", cyc, ea.cyc);
        chk("a_press", {28'b0, ifa.btn_press}, {28'b0, ea.press});
        chk("a_release", {28'b0, ifa.btn_release}, {28'b0, ea.rel});
        chk("a_level", {28'b0, ifa.btn_level}, {28'b0, ea.lvl});
      end
    end
  end

  always @(negedge clk) begin
    if ((ifb.btn_press | ifb.btn_release) != 4'b0) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_strobe",
            {24'b0, ifb.btn_press, ifb.btn_release}, 32'h0);
      end else begin
        eb = qb.pop_front();
        chk("b_cycle", cyc, eb.cyc);
        chk("b_press", {28'b0, ifb.btn_press}, {28'b0, eb.press});
        chk("b_release", {28'b0, ifb.btn_release}, {28'b0, eb.rel});
        chk("b_level", {28'b0, ifb.btn_level}, {28'b0, eb.lvl});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ifa.btn_raw = 4'b0000;
    ifb.btn_raw = 4'b1111;
    ifb.tick_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_level", {28'b0, ifa.btn_level}, 32'h0);
    chk("rst_a_strobes",
        {24'b0, ifa.btn_press, ifa.btn_release}, 32'h0);
    chk("rst_b_level", {28'b0, ifb.btn_level}, 32'h0);
    chk("rst_b_strobes",
        {24'b0, ifb.btn_press, ifb.btn_release}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // clean press on ch0
    align();
    ifa.btn_raw[0] = 1'b1;
    push_a(cyc + 15, 4'b0001, 4'b0000, 4'b0001);
    repeat (20) @(negedge clk);
    chk("t1_level", {28'b0, ifa.btn_level}, 32'h1);

    // bounce on ch1, then settle high
    for (int i = 0; i < 14; i++) begin
      ifa.btn_raw[1] = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    align();
    ifa.btn_raw[1] = 1'b1;
    push_a(cyc + 15, 4'b0010, 4'b0000, 4'b0011);
    repeat (20) @(negedge clk);

    // release ch0
    align();
    ifa.btn_raw[0] = 1'b0;
    push_a(cyc + 15, 4'b0000, 4'b0001, 4'b0010);
    repeat (20) @(negedge clk);

    // glitch on ch2 for three ticks only
    align();
    ifa.btn_raw[2] = 1'b1;
    repeat (12) @(negedge clk);
    ifa.btn_raw[2] = 1'b0;
    repeat (12) @(negedge clk);
    chk("t4_level", {28'b0, ifa.btn_level}, 32'h2);

    // active-low, single tick: coincident presses on ch0/ch3
    @(negedge clk);
    ifb.btn_raw[0] = 1'b0;
    ifb.btn_raw[3] = 1'b0;
    push_b(cyc + 3, 4'b1001, 4'b0000, 4'b1001);
    repeat (6) @(negedge clk);
    ifb.btn_raw[3] = 1'b1;
    push_b(cyc + 3, 4'b0000, 4'b1000, 4'b0001);
    repeat (6) @(negedge clk);

    // reset after two of four ticks on ch3
    align();
    ifa.btn_raw[3] = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_a_level", {28'b0, ifa.btn_level}, 32'h0);
    chk("t6_a_strobes",
        {24'b0, ifa.btn_press, ifa.btn_release}, 32'h0);
    chk("t6_b_level", {28'b0, ifb.btn_level}, 32'h0);
    repeat (5) @(negedge clk);
    align();
    rst_n = 1'b1;
    push_a(cyc + 15, 4'b1010, 4'b0000, 4'b1010);
    push_b(cyc + 3, 4'b0001, 4'b0000, 4'b0001);
    repeat (24) @(negedge clk);
    chk("end_a_level", {28'b0, ifa.btn_level}, 32'ha);
    chk("end_b_level", {28'b0, ifb.btn_level}, 32'h1);
    chk("a_queue_left", qa.size(), 32'h0);
    chk("b_queue_left", qb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
